// File: rtl/riscv_imem_arbiter.sv
// Two-master round-robin arbiter in front of the single instruction-memory port.
// Keeps the selection fixed while a request is stalled, and records the owner of
// every granted fetch in a small FIFO. In-order rvalid is routed back to that owner.
module riscv_imem_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_pmp_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_pmp_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_pmp_i,
    output logic        busy_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                     state_q, state_d;
    logic                       lock_sel_q, lock_sel_d;
    logic                       rr_q, rr_d;      // 1: master 1 has priority
    logic [CW-1:0]              count_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] owner_q;

    logic full, sel, sel_req, done, push, pop, head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Full comes from the registered count only, so rvalid never reaches instr_req_o.
    assign full = (count_q == CW'(MAX_OUTSTANDING));
    assign pop  = instr_rvalid_i & (count_q != '0);
    assign head = owner_q[rd_ptr_q];

    // Selection, memory-side request and the arbitration FSM next state.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        rr_d       = rr_q;
        if (state_q == LOCKED)
            sel = lock_sel_q;
        else if (m0_req_i && m1_req_i)
            sel = rr_q;
        else
            sel = m1_req_i & ~m0_req_i;
        sel_req      = sel ? m1_req_i : m0_req_i;
        instr_req_o  = sel_req & ~full;
        instr_addr_o = instr_req_o ? (sel ? m1_addr_i : m0_addr_i) : 32'h0;
        done         = instr_req_o & (instr_gnt_i | instr_err_pmp_i);
        push         = instr_req_o & instr_gnt_i & ~instr_err_pmp_i;
        unique case (state_q)
            ARB: begin
                if (done) begin
                    rr_d = ~sel;
                end else if (instr_req_o) begin
                    state_d    = LOCKED;
                    lock_sel_d = sel;
                end
            end
            LOCKED: begin
                if (!sel_req) begin
                    state_d = ARB;          // master withdrew its request
                end else if (done) begin
                    rr_d    = ~sel;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Master-side grant, error and response routing.
    always_comb begin
        m0_gnt_o     = instr_req_o & instr_gnt_i & ~sel;
        m1_gnt_o     = instr_req_o & instr_gnt_i & sel;
        m0_err_pmp_o = instr_req_o & instr_err_pmp_i & ~sel;
        m1_err_pmp_o = instr_req_o & instr_err_pmp_i & sel;
        m0_rvalid_o  = pop & ~head;
        m1_rvalid_o  = pop & head;
        m0_rdata_o   = instr_rdata_i;
        m1_rdata_o   = instr_rdata_i;
        busy_o       = (count_q != '0) | instr_req_o;
    end

    // FSM state, round-robin pointer and owner FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            lock_sel_q <= 1'b0;
            rr_q       <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            rr_q       <= rr_d;
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);
        end
    end

    // A response with nothing outstanding is a memory protocol violation; it is dropped.
    assert property (@(posedge clk) disable iff (!rst_n) !(instr_rvalid_i && count_q == '0))
        else $warning("riscv_imem_arbiter: rvalid with no outstanding fetch dropped");

endmodule
